// File: rtl/sobel_pkg.sv
// sobel_pkg: widths, default line length and read-FSM states shared by the Sobel window generator
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam int DEF_IMG_WIDTH = 512;
  typedef enum logic {R_IDLE, R_READ} rd_state_e;
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one image line, single write port, three adjacent pixels read combinationally
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  localparam int CW = $clog2(IMG_WIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [CW-1:0]     wr_col,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [CW-1:0]     rd_col,
  output logic [3*PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] mem [IMG_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[wr_col] <= wr_data;
  assign rd_data = {mem[rd_col + CW'(2)], mem[rd_col + CW'(1)], mem[rd_col]};
endmodule

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: four rotating line buffers feeding a registered 3x3 window stream
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PIX_W-1:0] PIXEL_IN,
  input  logic             PIXEL_IN_VALID,
  output logic [WIN_W-1:0] PIXEL_DATA,
  output logic             DATA_VALID,
  output logic             LINE_DONE
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int FW = $clog2(4*IMG_WIDTH+1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] RD_LAST = CW'(IMG_WIDTH-3);
  localparam logic [FW-1:0] LINE = FW'(IMG_WIDTH);
  localparam logic [FW-1:0] START = FW'(3*IMG_WIDTH);
  logic [CW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [1:0] wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [FW-1:0] fill_cnt_q, fill_cnt_d;
  rd_state_e state_q, state_d;
  logic [WIN_W-1:0] data_q, data_d, win;
  logic valid_q, valid_d, done_q, done_d, wr_last, rel;
  logic [3*PIX_W-1:0] lb_rd [4];
  for (genvar g = 0; g < 4; g++) begin : g_lb
    sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
      .clk(CLK),
      .we(PIXEL_IN_VALID && wr_sel_q == 2'(g)),
      .wr_col(wr_col_q),
      .wr_data(PIXEL_IN),
      .rd_col(rd_col_q),
      .rd_data(lb_rd[g])
    );
  end
  // rel marks the last read column: the oldest line is released in the same cycle
  always_comb begin
    wr_last = wr_col_q == COL_LAST;
    rel = state_q == R_READ && rd_col_q == RD_LAST;
    wr_col_d = PIXEL_IN_VALID ? (wr_last ? '0 : wr_col_q + CW'(1)) : wr_col_q;
    wr_sel_d = wr_sel_q + 2'(PIXEL_IN_VALID && wr_last);
    fill_cnt_d = fill_cnt_q + FW'(PIXEL_IN_VALID) - (rel ? LINE : '0);
    state_d = state_q == R_IDLE ? (fill_cnt_q >= START ? R_READ : R_IDLE) : (rel ? R_IDLE : R_READ);
    rd_col_d = (state_q == R_READ && !rel) ? rd_col_q + CW'(1) : '0;
    rd_sel_d = rd_sel_q + 2'(rel);
    win = '0;
    for (int r = 0; r < 3; r++) win[r*3*PIX_W +: 3*PIX_W] = lb_rd[rd_sel_q + 2'(r)];
    data_d = state_q == R_READ ? win : '0;
    valid_d = state_q == R_READ;
    done_d = rel;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_col_q <= '0;
      wr_sel_q <= '0;
      rd_col_q <= '0;
      rd_sel_q <= '0;
      fill_cnt_q <= '0;
      state_q <= R_IDLE;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wr_col_q <= wr_col_d;
      wr_sel_q <= wr_sel_d;
      rd_col_q <= rd_col_d;
      rd_sel_q <= rd_sel_d;
      fill_cnt_q <= fill_cnt_d;
      state_q <= state_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
    end
  end
  assign PIXEL_DATA = data_q;
  assign DATA_VALID = valid_q;
  assign LINE_DONE = done_q;
endmodule
